// File: rtl/n_bit_universal_shift_register.sv
// N-bit universal shift register: hold/shift/rotate/load/clear, single-step via en
// or a counted burst via start/cnt. Optional registered parity output under USR_PARITY_EN.
module n_bit_universal_shift_register #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    mode,
    input  logic          en,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    input  logic [N-1:0]  d,
    input  logic          sin_l,
    input  logic          sin_r,
    output logic [N-1:0]  q,
    output logic          sout_l,
    output logic          sout_r,
    output logic          busy,
    output logic          done,
    output logic          par
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  q_reg, q_next, op_result;
    logic [N-1:1]  q_up;
    logic [N-2:0]  q_dn;
    logic [2:0]    bmode_reg, bmode_next, op_mode;
    logic [CW-1:0] rem_reg, rem_next;
    logic          done_reg, done_next;
    logic          write_q;

    // Bit-level neighbours; fill bits for each shift/rotate are spliced in below.
    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_shift
            assign q_up[gi]   = q_reg[gi-1];
            assign q_dn[gi-1] = q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            bmode_reg <= '0;
            rem_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            bmode_reg <= bmode_next;
            rem_reg   <= rem_next;
            done_reg  <= done_next;
        end
    end

    // In BURST the latched mode drives the datapath; live mode/start/en are ignored.
    always_comb begin
        state_next = state_reg;
        bmode_next = bmode_reg;
        rem_next   = rem_reg;
        done_next  = 1'b0;
        write_q    = 1'b0;
        op_mode    = mode;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cnt != '0) begin
                        state_next = BURST;
                        bmode_next = mode;
                        rem_next   = cnt;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (en) begin
                    write_q = 1'b1;
                end
            end
            BURST: begin
                op_mode  = bmode_reg;
                write_q  = 1'b1;
                rem_next = rem_reg - 1'b1;
                if (rem_reg == CW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_result = q_reg;
        case (op_mode)
            3'b000: op_result = q_reg;
            3'b001: op_result = {q_up, sin_l};
            3'b010: op_result = {sin_r, q_dn};
            3'b011: op_result = {q_reg[N-1], q_dn};
            3'b100: op_result = {q_up, q_reg[N-1]};
            3'b101: op_result = {q_reg[0], q_dn};
            3'b110: op_result = d;
            3'b111: op_result = '0;
            default: op_result = q_reg;
        endcase
        q_next = write_q ? op_result : q_reg;
    end

    always_comb begin
        q      = q_reg;
        sout_l = q_reg[N-1];
        sout_r = q_reg[0];
        busy   = (state_reg == BURST);
        done   = done_reg;
    end

`ifdef USR_PARITY_EN
    logic par_reg;

    // Parity tracks q_next so it lines up with the cycle q shows the new value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            par_reg <= 1'b0;
        end else if (write_q) begin
            par_reg <= ^q_next;
        end
    end

    assign par = par_reg;
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_universal_shift_register.sv
// Directed testbench for n_bit_universal_shift_register (N=4, CW=4); parity expectations
// follow USR_PARITY_EN.
module tb_n_bit_universal_shift_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic       en;
    logic       start;
    logic [3:0] cnt;
    logic [3:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;
    logic       par;

    int tests_run = 0;
    int tests_failed = 0;

    n_bit_universal_shift_register #(.N(4), .CW(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .en(en), .start(start), .cnt(cnt),
        .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l),
        .sout_r(sout_r), .busy(busy), .done(done), .par(par)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        mode = 3'b110; d = v; en = 1'b1; start = 1'b0;
        tick();
        en = 1'b0;
    endtask

    task automatic step(input logic [2:0] m, input logic [3:0] v, input logic [3:0] exp, input string tag);
        load(v);
        mode = m; en = 1'b1;
        tick();
        en = 1'b0;
        check(tag, {4'h0, q}, {4'h0, exp});
    endtask

    logic par_on;

    initial begin
`ifdef USR_PARITY_EN
        par_on = 1'b1;
`else
        par_on = 1'b0;
`endif
        rst = 1'b0; mode = 3'b000; en = 1'b0; start = 1'b0; cnt = 4'd0;
        d = 4'd0; sin_l = 1'b0; sin_r = 1'b0;
        tick();
        check("por_q", {4'h0, q}, 8'h00);
        check("por_busy", {7'h0, busy}, 8'h0);
        check("por_par", {7'h0, par}, 8'h0);

        // 1. reset overrides a start
        rst = 1'b1;
        load(4'b1011);
        check("pre_rst_q", {4'h0, q}, 8'h0b);
        rst = 1'b0; start = 1'b1; cnt = 4'd3;
        tick();
        check("rst_q", {4'h0, q}, 8'h00);
        check("rst_busy", {7'h0, busy}, 8'h0);
        check("rst_done", {7'h0, done}, 8'h0);
        check("rst_souts", {6'h0, sout_l, sout_r}, 8'h0);
        check("rst_par", {7'h0, par}, 8'h0);
        rst = 1'b1; start = 1'b0; cnt = 4'd0;

        // 2. single-step operations
        load(4'b1010);
        check("load_q", {4'h0, q}, 8'h0a);
        check("load_souts", {6'h0, sout_l, sout_r}, 8'h2);
        mode = 3'b001; sin_l = 1'b1; en = 1'b1; tick();
        check("shl_q", {4'h0, q}, 8'h05);
        mode = 3'b011; tick();
        check("sra_q", {4'h0, q}, 8'h02);
        en = 1'b0; sin_l = 1'b0;
        step(3'b101, 4'b1010, 4'b0101, "ror_q");
        step(3'b000, 4'b1010, 4'b1010, "hold_q");
        step(3'b111, 4'b1010, 4'b0000, "clr_q");
        step(3'b100, 4'b1010, 4'b0101, "rol_q");
        sin_r = 1'b1;
        step(3'b010, 4'b1010, 4'b1101, "shr_q");
        step(3'b011, 4'b1010, 4'b1101, "sra_neg_q");
        sin_r = 1'b0;
        load(4'b1010);
        mode = 3'b001; en = 1'b0; tick();
        check("no_en_q", {4'h0, q}, 8'h0a);
        check("no_en_busy", {7'h0, busy}, 8'h0);

        // 3. burst rotate left x3, mode changed mid-burst
        load(4'b0001);
        mode = 3'b100; start = 1'b1; cnt = 4'd3; tick();
        start = 1'b0; mode = 3'b111;
        check("b3_c0", {2'h0, busy, done, q}, 8'h21);
        tick(); check("b3_c1", {2'h0, busy, done, q}, 8'h22);
        tick(); check("b3_c2", {2'h0, busy, done, q}, 8'h24);
        tick(); check("b3_done", {2'h0, busy, done, q}, 8'h18);
        tick(); check("b3_after", {2'h0, busy, done, q}, 8'h08);

        // 4a. zero-length burst
        start = 1'b1; cnt = 4'd0; tick();
        start = 1'b0;
        check("cnt0_pulse", {2'h0, busy, done, q}, 8'h18);
        tick(); check("cnt0_after", {2'h0, busy, done, q}, 8'h08);

        // 4b. start beats en; load burst with live d; back-to-back start in done cycle
        mode = 3'b110; d = 4'b1111; start = 1'b1; en = 1'b1; cnt = 4'd2; tick();
        start = 1'b0; en = 1'b0;
        check("prio_c0", {2'h0, busy, done, q}, 8'h28);
        tick(); check("prio_c1", {2'h0, busy, done, q}, 8'h2f);
        d = 4'b0011;
        tick(); check("prio_done", {2'h0, busy, done, q}, 8'h13);
        mode = 3'b001; sin_l = 1'b0; start = 1'b1; cnt = 4'd1; tick();
        start = 1'b0;
        check("b2b_c0", {2'h0, busy, done, q}, 8'h23);
        tick(); check("b2b_done", {2'h0, busy, done, q}, 8'h16);
        tick(); check("b2b_after", {2'h0, busy, done, q}, 8'h06);

        // 5. reset aborts a burst without a done pulse
        load(4'b1111);
        mode = 3'b010; sin_r = 1'b0; start = 1'b1; cnt = 4'd5; tick();
        start = 1'b0;
        tick(); tick();
        check("abort_pre", {2'h0, busy, done, q}, 8'h23);
        rst = 1'b0; tick();
        check("abort_rst", {2'h0, busy, done, q}, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort_idle%0d", i), {2'h0, busy, done, q}, 8'h00);
        end

        // 6. parity
        load(4'b1011);
        check("par_load", {7'h0, par}, {7'h0, par_on});
        mode = 3'b001; sin_l = 1'b1; en = 1'b1; tick();
        en = 1'b0;
        check("par_shl_q", {4'h0, q}, 8'h07);
        check("par_shl", {7'h0, par}, {7'h0, par_on});
        load(4'b0011);
        check("par_even", {7'h0, par}, 8'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
